input_pulse_conditioner: RTL and testbench
==========================================

# input_pulse_conditioner

Multi-channel input conditioner that turns raw slide-switch and push-button levels into clean, single-cycle command pulses. It sits directly upstream of the BCD counter bank, on the same divided scan clock. Its `rise` outputs drive the counters' `up`/`down`/`set` inputs (ORed with carry/borrow as today), replacing the ad-hoc per-switch flip-flop/pulser chains. Each channel is a 2-flop synchronizer, a consecutive-sample debouncer and an edge/auto-repeat pulse generator.

## Interface
- `WIDTH`, 8: number of independent input channels.
- `DEBOUNCE_CYCLES`, 4: consecutive disagreeing samples required to flip the debounced level; legal range ≥1.
- `REPEAT_DELAY`, 0: cycles from the initial rise pulse to the first auto-repeat pulse while held; 0 disables auto-repeat.
- `REPEAT_PERIOD`, 8: cycles between subsequent auto-repeat pulses; ≥1; ignored when `REPEAT_DELAY`=0.

Ports:
- `clk`  in  1  scan clock; all state on rising edge.
- `nreset`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `in`  in  WIDTH  raw asynchronous switch/button levels.
- `level`  out  WIDTH  debounced level per channel.
- `rise`  out  WIDTH  one-cycle pulse on debounced 0→1, plus auto-repeat pulses.
- `fall`  out  WIDTH  one-cycle pulse on debounced 1→0.

## Operation
- Channels are fully independent; identical logic per channel, generated over `WIDTH`.
- Synchronizer: `s1 <= in`, `s2 <= s1`; only `s2` feeds the debouncer.
- Debouncer: per-channel counter `dcnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - If `s2 == level`: `dcnt <= 0`.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`: `level <= s2`, `dcnt <= 0`.
  - Else: `dcnt <= dcnt+1`.
  - A single agreeing sample restarts the count; no partial credit.
- Per-channel state machine:
  - LOW: `level`=0.
  - HELD: `level`=1 and repeat pending.
  - In LOW, debounced rise → HELD, `rise` high for 1 cycle, `rcnt` loaded with `REPEAT_DELAY`.
  - In HELD, debounced fall → LOW, `fall` high for 1 cycle, `rcnt` cleared. No repeat pulse may be emitted on or after the fall cycle.
  - Auto-repeat (`REPEAT_DELAY`>0), in HELD each cycle: `rcnt` decrements. When it reaches 1, the next edge emits a `rise` pulse and reloads `rcnt` with `REPEAT_PERIOD`.
  - `rcnt` width is $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1); no wrap is permitted.
- `rise` and `fall` are registered outputs and are never high together on one channel.
- Reset, asserted anytime including mid-debounce or mid-repeat: `s1`, `s2`, `level`, `dcnt`, `rcnt`, `rise`, `fall` all 0, state LOW.
- An input already high at reset release is treated as a fresh rise. It pulses after synchronizer plus debounce latency.

## Timing
- Reset values: `level`=0, `rise`=0, `fall`=0 for all channels, asynchronously on `nreset` low.
- Rise latency: `in` stable high before edge N (no bounce) → `s2` high after N+1 → `level` and `rise` high after edge N+1+DEBOUNCE_CYCLES. `rise` clears after the next edge.
- Fall latency is symmetric: `level` low and `fall` high after edge N+1+DEBOUNCE_CYCLES.
- Auto-repeat: first repeat `rise` at cycle (initial rise)+REPEAT_DELAY, then every REPEAT_PERIOD cycles while `level`=1.
- Pulses shorter than DEBOUNCE_CYCLES samples (after sync) produce no `level` change and no pulse.
- Throughput: minimum spacing between rise and fall events on one channel is DEBOUNCE_CYCLES cycles.

## Test plan
- Reset/idle: `nreset`=0 with `in`=8'hFF, release at edge 0 → `level`=0, `rise`=0 until edge 6. At edge 6 `level`=8'hFF and `rise`=8'hFF for exactly 1 cycle (DEBOUNCE_CYCLES=4).
- Clean press/release: `in[3]` 0→1 before edge 10, held 20 cycles → `rise[3]` high only in cycle after edge 15. Release before edge 30 → `fall[3]` high only after edge 35; other bits stay 0.
- Bounce rejection: `in[0]` pattern 1,1,1,0,1,1,1,0 repeated → `level[0]` stays 0 and no pulse. Then steady 1 → exactly one `rise[0]` 4 samples after bounce ends.
- Auto-repeat (REPEAT_DELAY=10, REPEAT_PERIOD=5): hold `in[1]`, initial `rise[1]` at edge T → repeats at T+10, T+15, T+20. Release mid-period → `fall[1]` once, no further `rise[1]`.
- Simultaneous channels: `in[7]` rises as `in[6]` falls at the same edge → `rise[7]` and `fall[6]` in the same cycle, independent.
- Reset mid-operation: assert `nreset` while `dcnt[2]`=2 and channel 1 in HELD → all outputs 0 immediately. With `in` unchanged after release, the full 1+DEBOUNCE_CYCLES latency is required before `rise`.

Source files
------------

// File: rtl/input_pulse_conditioner.sv
// Multi-channel switch/button conditioner: per channel a 2-flop synchronizer,
// consecutive-sample debouncer and edge / auto-repeat single-cycle pulse generator.
module input_pulse_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] D_ONE    = DW'(1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);
    localparam logic [RW-1:0] R_ONE    = RW'(1);
    localparam bit            REPEAT_EN = (REPEAT_DELAY > 0);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HELD = 1'b1
    } ch_state_t;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          lvl;
        logic          rise_q;
        logic          fall_q;
        logic [DW-1:0] dcnt;
        logic [RW-1:0] rcnt;
        ch_state_t     state;
        logic          settle;

        // The debounced level flips on this edge.
        assign settle = (s2 != lvl) && (dcnt == D_LAST);

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                lvl  <= 1'b0;
                dcnt <= '0;
            end else begin
                s1 <= in[g];
                s2 <= s1;
                // Any agreeing sample discards all accumulated credit.
                if (s2 == lvl) begin
                    dcnt <= '0;
                end else if (dcnt == D_LAST) begin
                    lvl  <= s2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + D_ONE;
                end
            end
        end

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                state  <= ST_LOW;
                rcnt   <= '0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state)
                    ST_LOW: begin
                        if (settle) begin
                            state  <= ST_HELD;
                            rise_q <= 1'b1;
                            rcnt   <= R_DELAY;
                        end
                    end
                    ST_HELD: begin
                        // A release takes priority over a repeat due on the same edge.
                        if (settle) begin
                            state  <= ST_LOW;
                            fall_q <= 1'b1;
                            rcnt   <= '0;
                        end else if (REPEAT_EN) begin
                            if (rcnt == R_ONE) begin
                                rise_q <= 1'b1;
                                rcnt   <= R_PERIOD;
                            end else if (rcnt != '0) begin
                                rcnt <= rcnt - R_ONE;
                            end
                        end
                    end
                    default: begin
                        state <= ST_LOW;
                    end
                endcase
            end
        end

        assign level[g] = lvl;
        assign rise[g]  = rise_q;
        assign fall[g]  = fall_q;
    end

endmodule

// File: tb/tb_input_pulse_conditioner.sv
// Bench for input_pulse_conditioner: a no-repeat and an auto-repeat instance share
// stimulus and are compared against a sample-window reference model.
module tb_input_pulse_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] in_v = 8'h00;
    logic [7:0] level0, rise0, fall0;
    logic [7:0] level1, rise1, fall1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    input_pulse_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(DB)) dut0 (
        .clk(clk), .nreset(nreset), .in(in_v),
        .level(level0), .rise(rise0), .fall(fall0)
    );

    input_pulse_conditioner #(.WIDTH(8), .DEBOUNCE_CYCLES(DB),
                              .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut1 (
        .clk(clk), .nreset(nreset), .in(in_v),
        .level(level1), .rise(rise1), .fall(fall1)
    );

    // Reference model: k counts edges since reset release; the debouncer at edge k
    // sees the input sampled at edge k-2. The level flips when the last DB such
    // samples all disagree with it. Repeats fall RD, RD+RP, ... edges after a rise.
    logic [7:0] in_hist [0:8191];
    int         k;
    int         rise_t [8];
    logic [7:0] m_level, e_rise0, e_rise1, e_fall;
    bit         all_diff;
    bit         smp;
    int         idx;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            k       = 0;
            m_level = 8'h00;
            e_rise0 = 8'h00;
            e_rise1 = 8'h00;
            e_fall  = 8'h00;
        end else begin
            k = k + 1;
            in_hist[k] = in_v;
            e_rise0 = 8'h00;
            e_rise1 = 8'h00;
            e_fall  = 8'h00;
            for (int c = 0; c < 8; c++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    idx = k - 2 - j;
                    smp = (idx >= 1) ? in_hist[idx][c] : 1'b0;
                    if (smp == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        e_rise0[c] = 1'b1;
                        e_rise1[c] = 1'b1;
                        rise_t[c]  = k;
                    end else begin
                        e_fall[c] = 1'b1;
                    end
                end else if (m_level[c] && (k - rise_t[c] >= RD) &&
                             ((k - rise_t[c] - RD) % RP == 0)) begin
                    e_rise1[c] = 1'b1;
                end
            end
        end
    end

    logic [47:0] obs_v, exp_v;
    assign obs_v = {level0, rise0, fall0, level1, rise1, fall1};
    assign exp_v = {m_level, e_rise0, e_fall, m_level, e_rise1, e_fall};

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        in_v   = 8'hFF;
        run_cycles(2);
        #1;
        if (obs_v !== 48'h0) begin
            errors++;
            $display("FAIL reset_state: got=%h want=0", obs_v);
        end
        checks++;
        @(negedge clk);
        nreset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_release k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (k < 6 && (level0 !== 8'h00 || rise0 !== 8'h00)) begin
                errors++;
                $display("FAIL early_rise k=%0d: level=%h rise=%h want 00/00", k, level0, rise0);
            end
            if (k == 6) begin
                if (level0 !== 8'hFF || rise0 !== 8'hFF) begin
                    errors++;
                    $display("FAIL release_rise k=6: level=%h rise=%h want ff/ff", level0, rise0);
                end
                checks++;
            end
            if (k == 7) begin
                if (rise0 !== 8'h00) begin
                    errors++;
                    $display("FAIL rise_width k=7: rise=%h want 00", rise0);
                end
                checks++;
            end
        end
        in_v = 8'h00;
        run_cycles(10);
    endtask

    task automatic test_press_release();
        int k_press, k_rel;
        k_press = k + 1;
        in_v[3] = 1'b1;
        k_rel = -100;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL press_model k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (rise0 !== ((k == k_press + 5) ? 8'h08 : 8'h00)) begin
                errors++;
                $display("FAIL press_rise k=%0d: rise=%h", k, rise0);
            end
            checks++;
            if (fall0 !== ((k == k_rel + 5) ? 8'h08 : 8'h00)) begin
                errors++;
                $display("FAIL release_fall k=%0d: fall=%h", k, fall0);
            end
            checks++;
            if (n == 19) begin
                in_v[3] = 1'b0;
                k_rel   = k + 1;
            end
        end
    endtask

    task automatic test_bounce();
        int k_steady, n_rise;
        n_rise = 0;
        for (int n = 0; n < 24; n++) begin
            in_v[0] = (n % 4 != 3);
            @(negedge clk);
            if (obs_v !== exp_v || level0[0] !== 1'b0 || rise0[0] !== 1'b0) begin
                errors++;
                $display("FAIL bounce k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
        end
        in_v[0]  = 1'b1;
        k_steady = k + 1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL bounce_steady k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (rise0[0]) begin
                n_rise++;
                if (k != k_steady + 5) begin
                    errors++;
                    $display("FAIL bounce_rise_time: k=%0d want %0d", k, k_steady + 5);
                end
            end
        end
        if (n_rise != 1) begin
            errors++;
            $display("FAIL bounce_rise_count: got=%0d want=1", n_rise);
        end
        checks++;
        in_v = 8'h00;
        run_cycles(10);
    endtask

    task automatic test_repeat();
        int t_rise, n_rise, n_fall, last_rise;
        n_rise = 0;
        n_fall = 0;
        last_rise = 0;
        in_v[1] = 1'b1;
        t_rise  = k + 1 + 5;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL repeat_model k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (rise1[1]) begin
                n_rise++;
                last_rise = k;
            end
            if (fall1[1]) n_fall++;
            if (k + 1 >= t_rise + 25) in_v[1] = 1'b0;
        end
        if (n_rise != 5 || n_fall != 1 || last_rise != t_rise + 25) begin
            errors++;
            $display("FAIL repeat_counts: rises=%0d falls=%0d last=%0d want 5/1/%0d",
                     n_rise, n_fall, last_rise, t_rise + 25);
        end
        checks++;
        run_cycles(6);
    endtask

    task automatic test_simultaneous();
        int k_sw;
        in_v = 8'h40;
        run_cycles(10);
        in_v = 8'h80;
        k_sw = k + 1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL simul_model k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (k == k_sw + 5) begin
                if (rise0 !== 8'h80 || fall0 !== 8'h40) begin
                    errors++;
                    $display("FAIL simul_edge: rise=%h fall=%h want 80/40", rise0, fall0);
                end
                checks++;
            end
        end
        in_v = 8'h00;
        run_cycles(10);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) in_v[b] = ~in_v[b];
        end
        in_v = 8'h00;
        run_cycles(10);
    endtask

    task automatic test_reset_mid();
        in_v = 8'h02;
        run_cycles(9);
        in_v[2] = 1'b1;
        run_cycles(4);
        #2 nreset = 1'b0;
        #1;
        if (obs_v !== 48'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got=%h want=0", obs_v);
        end
        checks++;
        @(negedge clk);
        nreset = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_model k=%0d: got=%h want=%h", k, obs_v, exp_v);
            end
            checks++;
            if (rise0 !== ((k == 6) ? 8'h06 : 8'h00)) begin
                errors++;
                $display("FAIL reset_mid_rise k=%0d: rise=%h", k, rise0);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_repeat();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
